// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter and its helpers.
//   OWN_*      : owner codes recording which requester has an access in flight
//   *_W_DEF    : default address/data widths of the dmem port
//   BE_W       : byte-enable width of a 32-bit word
//   WAIT_W     : width of the anti-starvation wait counter
package dmem_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_VGA  = 2'd2;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = 4;
    localparam int WAIT_W     = 4;

endpackage

// File: rtl/dmem_arb_age_counter.sv
// Saturating age counter used to bound how long a requester can lose arbitration.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count returns to 0)
//   clr        : clear the count (wins over inc)
//   inc        : advance the count by one, sticking at MAX
//   at_max     : count has reached MAX
module dmem_arb_age_counter
    import dmem_arb_pkg::*;
#(
    parameter int CNT_W = WAIT_W,
    parameter int MAX   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [CNT_W-1:0] cnt;

    assign at_max = (cnt == CNT_W'(MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port synchronous data memory between the CPU data
// port and the VGA pixel-fetch port. VGA wins by default; a waiting CPU is
// granted once it has lost MAX_WAIT consecutive cycles. Read data returns one
// cycle after the grant to whichever requester issued the access.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   cpu_req/we/be/addr/wdata : CPU request, held stable until cpu_gnt
//   cpu_gnt               : combinational, CPU access issued this cycle
//   cpu_rvalid, cpu_rdata : response pulse one cycle after cpu_gnt, data held
//   vga_req, vga_addr     : VGA read request
//   vga_gnt               : combinational, VGA read issued this cycle
//   vga_rvalid, vga_rdata : response pulse one cycle after vga_gnt, data held
//   mem_en/we/be/addr/wdata : memory command, driven from the granted requester
//   mem_rdata             : memory read data, one cycle after mem_en
//
// In-flight owner (pend_own):
//   state    | meaning
//   OWN_NONE | no access issued last cycle
//   OWN_CPU  | last cycle's access belongs to the CPU; mem_rdata is its response
//   OWN_VGA  | last cycle's access belongs to VGA; mem_rdata is its response
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [BE_W-1:0]   cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              cpu_starved;
    logic              wait_clr;
    logic              wait_inc;
    logic [1:0]        pend_own;
    logic [1:0]        pend_own_nxt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vga_rdata_q;

    dmem_arb_age_counter #(
        .CNT_W (WAIT_W),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .at_max (cpu_starved)
    );

    // Grants stay combinational but are masked during reset so nothing is
    // issued to the memory while the arbiter is being cleared.
    always_comb begin
        cpu_gnt = 1'b0;
        vga_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && (!vga_req || cpu_starved)) begin
                cpu_gnt = 1'b1;
            end else if (vga_req) begin
                vga_gnt = 1'b1;
            end
        end
    end

    assign wait_clr = cpu_gnt || !cpu_req;
    assign wait_inc = cpu_req && !cpu_gnt;

    always_comb begin
        mem_en    = cpu_gnt | vga_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_be    = cpu_be;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (vga_gnt) begin
            mem_addr  = vga_addr;
        end
    end

    always_comb begin
        pend_own_nxt = OWN_NONE;
        if (cpu_gnt) begin
            pend_own_nxt = OWN_CPU;
        end else if (vga_gnt) begin
            pend_own_nxt = OWN_VGA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_own    <= OWN_NONE;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            pend_own <= pend_own_nxt;
            if (pend_own == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (pend_own == OWN_VGA) begin
                vga_rdata_q <= mem_rdata;
            end
        end
    end

    // mem_rdata is valid in the response cycle itself, so it is passed straight
    // through then and the captured copy holds it until the next response.
    always_comb begin
        cpu_rvalid = (pend_own == OWN_CPU);
        vga_rvalid = (pend_own == OWN_VGA);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;
    end

endmodule
